// File: rtl/ftdi_fifo_responder_if.sv
// Host-side FTDI-style FIFO bus plus the local push/pop ports of the responder.
interface ftdi_fifo_responder_if;
  logic       oe;
  logic       rd;
  logic       wr;
  logic       rxf;
  logic       txe;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       rx_push;
  logic [7:0] rx_push_data;
  logic       rx_full;
  logic       tx_pop;
  logic [7:0] tx_pop_data;
  logic       tx_empty;
  logic       proto_err;

  modport slave (
    input  oe, rd, wr, d_in, rx_push, rx_push_data, tx_pop,
    output rxf, txe, d_out, d_oe, rx_full, tx_pop_data, tx_empty, proto_err
  );

  modport master (
    output oe, rd, wr, d_in, rx_push, rx_push_data, tx_pop,
    input  rxf, txe, d_out, d_oe, rx_full, tx_pop_data, tx_empty, proto_err
  );
endinterface

// File: rtl/ftdi_fifo_responder.sv
// FTDI 245-style FIFO responder: RXQ carries local bytes to the host, TXQ
// carries host writes to the local side. Both queues are show-ahead.
// Optional host protocol checker enabled by macro FTDI_RESP_PROTO_CHECK_EN.
module ftdi_fifo_responder #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  ftdi_fifo_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];

  logic rx_empty_c, rx_full_c, rx_push_c, rx_pop_c;
  logic tx_empty_c, tx_full_c, tx_push_c, tx_pop_c;

  // Status decode and accepted push/pop qualification
  always_comb begin
    rx_empty_c = (rx_cnt_q == '0);
    rx_full_c  = (rx_cnt_q == CW'(DEPTH));
    tx_empty_c = (tx_cnt_q == '0);
    tx_full_c  = (tx_cnt_q == CW'(DEPTH));
    // A full RXQ drops the push even when the host pops on the same edge
    rx_push_c  = bus.rx_push && !rx_full_c;
    rx_pop_c   = !bus.rd && !bus.oe && !rx_empty_c;
    tx_push_c  = !bus.wr && !tx_full_c;
    tx_pop_c   = bus.tx_pop && !tx_empty_c;
  end

  // Next-state pointers and counts; simultaneous push/pop nets the count
  always_comb begin
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (rx_push_c) rx_wp_d = rx_wp_q + AW'(1);
    if (rx_pop_c)  rx_rp_d = rx_rp_q + AW'(1);
    if (tx_push_c) tx_wp_d = tx_wp_q + AW'(1);
    if (tx_pop_c)  tx_rp_d = tx_rp_q + AW'(1);
    case ({rx_push_c, rx_pop_c})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    case ({tx_push_c, tx_pop_c})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // Pointer and count registers, cleared asynchronously
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // Storage arrays; contents survive reset, only pointers are cleared
  always_ff @(posedge clk) begin
    if (rx_push_c) rx_mem_q[rx_wp_q] <= bus.rx_push_data;
    if (tx_push_c) tx_mem_q[tx_wp_q] <= bus.d_in;
  end

  assign bus.rxf         = rx_empty_c;
  assign bus.rx_full     = rx_full_c;
  assign bus.txe         = tx_full_c;
  assign bus.tx_empty    = tx_empty_c;
  assign bus.d_out       = rx_mem_q[rx_rp_q];
  assign bus.tx_pop_data = tx_mem_q[tx_rp_q];
  // Bus drive follows oe but is forced off while reset is held
  assign bus.d_oe        = n_rst & ~bus.oe;

`ifdef FTDI_RESP_PROTO_CHECK_EN
  logic proto_err_q, proto_err_d;

  // Sticky flag: read without output enable, or read and write together
  always_comb begin
    proto_err_d = proto_err_q;
    if ((!bus.rd && bus.oe) || (!bus.rd && !bus.wr)) proto_err_d = 1'b1;
  end

  // Protocol error register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) proto_err_q <= 1'b0;
    else        proto_err_q <= proto_err_d;
  end

  assign bus.proto_err = proto_err_q;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: doc/ftdi_fifo_responder.md
FTDI_FIFO_RESPONDER -- requirements
Module: ftdi_fifo_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4: log2 of the depth of each internal FIFO (16 entries).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port n_rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port oe  in  1  host output-enable, active low.
REQ-005 SHALL have port rd  in  1  host read strobe, active low.
REQ-006 SHALL have port wr  in  1  host write strobe, active low.
REQ-007 SHALL have port rxf  out  1  low = byte available to host.
REQ-008 SHALL have port txe  out  1  low = space available for host writes.
REQ-009 SHALL have port d_in  in  8  host-driven data bus, sampled on writes.
REQ-010 SHALL have port d_out  out  8  responder data toward host.
REQ-011 SHALL have port d_oe  out  1  high = d_out drives the shared bus.
REQ-012 SHALL have port rx_push / rx_push_data / rx_full  in/in/out  1/8/1  local side, fills the device-to-host FIFO.
REQ-013 SHALL have port tx_pop / tx_pop_data / tx_empty  in/out/out  1/8/1  local side, drains the host-to-device FIFO.
REQ-014 SHALL have port proto_err  out  1  sticky host protocol-violation flag.

Function
REQ-015 SHALL contain two FIFOs, RXQ (device to host) and TXQ (host to device), each 2^DEPTH_LOG2 x 8 with a DEPTH_LOG2+1-bit count; pointers wrap modulo depth.
REQ-016 SHALL drive rxf = 1 iff RXQ count == 0, and rx_full = 1 iff RXQ count == depth, both decoded from registered count.
REQ-017 SHALL pop RXQ at an edge where rd==0 && oe==0 && rxf==0; otherwise rd is ignored for data.
REQ-018 SHALL present the RXQ head combinationally on d_out (show-ahead); the head advances in the cycle after a pop.
REQ-019 SHALL drive d_oe = !oe while out of reset, and d_oe = 0 during reset.
REQ-020 SHALL push rx_push_data into RXQ on rx_push==1 only when rx_full==0; a push while full SHALL be dropped, even if the host pops in the same cycle.
REQ-021 SHALL drive txe = 1 iff TXQ count == depth, and tx_empty = 1 iff TXQ count == 0.
REQ-022 SHALL push d_in into TXQ at an edge where wr==0 && txe==0; a write while txe==1 SHALL be dropped.
REQ-023 SHALL present the TXQ head on tx_pop_data; tx_pop==1 while tx_empty==0 SHALL pop, and a pop while empty SHALL be ignored.
REQ-024 SHALL net each FIFO's count for a simultaneous valid push and pop (count unchanged, both pointers advance).
REQ-025 SHALL treat simultaneous host read and host write on the same edge as independent, performing both.
REQ-026 SHALL give 1-cycle latency from a local push to rxf falling, and from a host write to tx_empty falling.

Reset
REQ-027 SHALL, on n_rst low, immediately clear both FIFOs' pointers and counts, giving rxf=1, rx_full=0, txe=0, tx_empty=1, proto_err=0, d_oe=0; FIFO contents are not cleared.
REQ-028 SHALL abort any in-progress host transfer on reset mid-operation, with no pop or push at that edge; operation resumes on the first edge after release.

Configuration
REQ-029 SHALL honour macro FTDI_RESP_PROTO_CHECK_EN: when defined, proto_err sets on any edge with rd==0 && oe==1, or with rd==0 && wr==0, and holds until reset.
REQ-030 SHALL, when FTDI_RESP_PROTO_CHECK_EN is undefined, tie proto_err to 0 and omit the checker logic; data behaviour is identical in both builds.

Verification
REQ-031 SHALL cover: local push 0xA5 then 0x3C; host oe=0, then rd=0 for 2 cycles -> d_out 0xA5 then 0x3C, rxf returns to 1 after the second pop.
REQ-032 SHALL cover: 16 local pushes plus a 17th of 0xFF -> rx_full=1, 17th dropped; 16 host reads return the original order, with no 0xFF.
REQ-033 SHALL cover: host writes 0x00..0x0F with wr=0 -> txe=1 after the 16th; a 17th write is dropped; local pops yield 0x00..0x0F and then tx_empty=1.
REQ-034 SHALL cover: RXQ count 5 with simultaneous local push and host pop -> count stays 5 and data order is preserved.
REQ-035 SHALL cover: with FTDI_RESP_PROTO_CHECK_EN defined, rd=0 while oe=1 -> proto_err=1, no pop, and proto_err holds until n_rst pulses low.
REQ-036 SHALL cover: n_rst asserted during a host read burst -> rxf=1 and d_oe=0 immediately, and the count is 0 after release.
